// File: rtl/psx_pkg.sv
// Shared types and constants for the PlayStation controller poller.
package psx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSel,
    StShift,
    StAckw,
    StDesel
  } psx_state_e;

  localparam logic [7:0] CMD_START = 8'h01;
  localparam logic [7:0] CMD_POLL  = 8'h42;

  // Byte the host sends at a given packet index.
  function automatic logic [7:0] tx_byte(input logic [4:0] idx);
    if (idx == 5'd0) return CMD_START;
    if (idx == 5'd1) return CMD_POLL;
    return 8'h00;
  endfunction

  // Packet length announced by the ID byte, clamped to the buffer limit.
  function automatic logic [4:0] pkt_len(input logic [7:0] id, input int unsigned pkt_max);
    logic [5:0] raw;
    raw = 6'd3 + {1'b0, id[3:0], 1'b0};
    if (raw > 6'(pkt_max)) return 5'(pkt_max);
    return raw[4:0];
  endfunction

endpackage

// File: rtl/psx_shifter.sv
// 8-bit LSB-first full-duplex shifter. A byte spans 16 half periods: the clock
// falls at even half starts (MOSI updates) and rises at odd half starts (MISO sampled).
module psx_shifter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] tx_byte_i,
  input  logic       en_i,
  input  logic       tick_i,
  input  logic       miso_i,
  output logic       sclk_o,
  output logic       mosi_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_vld_o,
  output logic       done_o
);

  logic [3:0] half_q, half_d;
  logic [7:0] tx_q, tx_d, rx_q, rx_d, byte_q, byte_d;
  logic       sclk_q, sclk_d, mosi_q, mosi_d, vld_q, vld_d;
  logic       step;

  assign step = en_i & tick_i;

  // Next-state: load drives the first falling edge, each tick advances one half period.
  always_comb begin
    half_d = half_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    byte_d = byte_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    vld_d  = 1'b0;
    if (load_i) begin
      half_d = 4'd0;
      sclk_d = 1'b0;
      mosi_d = tx_byte_i[0];
      tx_d   = {1'b0, tx_byte_i[7:1]};
    end else if (step) begin
      half_d = half_q + 4'd1;
      if (!half_q[0]) begin
        sclk_d = 1'b1;
        rx_d   = {miso_i, rx_q[7:1]};
        if (half_q == 4'd14) begin
          byte_d = {miso_i, rx_q[7:1]};
          vld_d  = 1'b1;
        end
      end else if (half_q != 4'd15) begin
        sclk_d = 1'b0;
        mosi_d = tx_q[0];
        tx_d   = {1'b0, tx_q[7:1]};
      end
    end
  end

  // Shifter state; clock idles high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      half_q <= 4'd0;
      tx_q   <= 8'h00;
      rx_q   <= 8'h00;
      byte_q <= 8'h00;
      sclk_q <= 1'b1;
      mosi_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      half_q <= half_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
      byte_q <= byte_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      vld_q  <= vld_d;
    end
  end

  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;
  assign rx_byte_o = byte_q;
  assign rx_vld_o  = vld_q;
  assign done_o    = step & (half_q == 4'd15);

endmodule

// File: rtl/psx_poller.sv
// Polls each controller port in turn: select, shift command/response bytes,
// wait for the pad's ACK between bytes, deselect, move to the next port.
module psx_poller
  import psx_pkg::*;
#(
  parameter int unsigned HALF_PER    = 3500,
  parameter int unsigned N_PORTS     = 2,
  parameter int unsigned PKT_MAX     = 9,
  parameter int unsigned ACK_TIMEOUT = 1000
) (
  input  logic               iCLK,
  input  logic               iRESET,
  input  logic               iSTART,
  input  logic               iAUTO,
  output logic [N_PORTS-1:0] oCS,
  output logic               oCLK,
  output logic               oMOSI,
  input  logic               iMISO,
  input  logic               iACK,
  output logic [7:0]         oBYTE,
  output logic               oBYTE_VLD,
  output logic [4:0]         oBYTE_IDX,
  output logic [1:0]         oPORT,
  output logic               oFRAME_END,
  output logic [N_PORTS-1:0] oNO_PAD,
  output logic               oBUSY
);

  localparam int unsigned TOW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  psx_state_e         state_q, state_d;
  logic [11:0]        hp_q, hp_d;
  logic [1:0]         port_q, port_d, dcnt_q, dcnt_d;
  logic [4:0]         idx_q, idx_d, len_q, len_d;
  logic [TOW-1:0]     to_q, to_d;
  logic               ack_seen_q, ack_seen_d;
  logic [N_PORTS-1:0] nopad_q, nopad_d;
  logic [1:0]         miso_sync_q, ack_sync_q;
  logic               tick, is_last, last_port, load, done, rx_vld;
  logic [7:0]         rx_byte;

  assign tick      = (hp_q == 12'(HALF_PER - 1));
  assign is_last   = (idx_q == len_q - 5'd1);
  assign last_port = (port_q == 2'(N_PORTS - 1));

  // Two-flop synchronisers; ACK idles high.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      miso_sync_q <= 2'b00;
      ack_sync_q  <= 2'b11;
    end else begin
      miso_sync_q <= {miso_sync_q[0], iMISO};
      ack_sync_q  <= {ack_sync_q[0], iACK};
    end
  end

  psx_shifter u_shifter (
    .clk_i     (iCLK),
    .rst_ni    (iRESET),
    .load_i    (load),
    .tx_byte_i (tx_byte(idx_q)),
    .en_i      (state_q == StShift),
    .tick_i    (tick),
    .miso_i    (miso_sync_q[1]),
    .sclk_o    (oCLK),
    .mosi_o    (oMOSI),
    .rx_byte_o (rx_byte),
    .rx_vld_o  (rx_vld),
    .done_o    (done)
  );

  // FSM next-state, half-period counter, ACK timeout and per-port flags.
  always_comb begin
    state_d    = state_q;
    hp_d       = tick ? 12'd0 : hp_q + 12'd1;
    port_d     = port_q;
    dcnt_d     = dcnt_q;
    idx_d      = idx_q;
    len_d      = len_q;
    to_d       = to_q;
    ack_seen_d = ack_seen_q;
    nopad_d    = nopad_q;
    load       = 1'b0;
    unique case (state_q)
      StIdle: begin
        hp_d = 12'd0;
        if (iSTART || iAUTO) begin
          state_d = StSel;
          port_d  = 2'd0;
          idx_d   = 5'd0;
          len_d   = 5'(PKT_MAX);
        end
      end
      StSel: begin
        if (tick) begin
          state_d = StShift;
          load    = 1'b1;
        end
      end
      StShift: begin
        if (rx_vld && idx_q == 5'd1) len_d = pkt_len(rx_byte, PKT_MAX);
        if (rx_vld && is_last) begin
          for (int p = 0; p < int'(N_PORTS); p++) if (port_q == 2'(p)) nopad_d[p] = 1'b0;
        end
        if (done) begin
          if (is_last) begin
            state_d = StDesel;
            dcnt_d  = 2'd0;
          end else begin
            state_d    = StAckw;
            idx_d      = idx_q + 5'd1;
            to_d       = '0;
            ack_seen_d = 1'b0;
          end
        end
      end
      StAckw: begin
        if (!ack_seen_q) begin
          // Counter parked at zero so the post-ACK delay is a full half period.
          hp_d = 12'd0;
          to_d = to_q + TOW'(1);
          if (!ack_sync_q[1]) begin
            ack_seen_d = 1'b1;
          end else if (to_q == TOW'(ACK_TIMEOUT - 1)) begin
            for (int p = 0; p < int'(N_PORTS); p++) if (port_q == 2'(p)) nopad_d[p] = 1'b1;
            state_d = StDesel;
            dcnt_d  = 2'd0;
          end
        end else if (tick) begin
          state_d = StShift;
          load    = 1'b1;
        end
      end
      StDesel: begin
        if (tick) begin
          dcnt_d = dcnt_q + 2'd1;
          if (dcnt_q == 2'd3) begin
            if (!last_port || iAUTO) begin
              state_d = StSel;
              port_d  = last_port ? 2'd0 : port_q + 2'd1;
              idx_d   = 5'd0;
              len_d   = 5'(PKT_MAX);
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state registers.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q    <= StIdle;
      hp_q       <= 12'd0;
      port_q     <= 2'd0;
      dcnt_q     <= 2'd0;
      idx_q      <= 5'd0;
      len_q      <= 5'(PKT_MAX);
      to_q       <= '0;
      ack_seen_q <= 1'b0;
      nopad_q    <= '0;
    end else begin
      state_q    <= state_d;
      hp_q       <= hp_d;
      port_q     <= port_d;
      dcnt_q     <= dcnt_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      to_q       <= to_d;
      ack_seen_q <= ack_seen_d;
      nopad_q    <= nopad_d;
    end
  end

  // Only the active port's select is driven low, and only while it owns the bus.
  always_comb begin
    oCS = '1;
    if (state_q == StSel || state_q == StShift || state_q == StAckw) begin
      for (int p = 0; p < int'(N_PORTS); p++) if (port_q == 2'(p)) oCS[p] = 1'b0;
    end
  end

  assign oBYTE      = rx_byte;
  assign oBYTE_VLD  = rx_vld;
  assign oBYTE_IDX  = idx_q;
  assign oPORT      = port_q;
  assign oFRAME_END = rx_vld & is_last;
  assign oNO_PAD    = nopad_q;
  assign oBUSY      = (state_q != StIdle);

endmodule

// File: tb/tb_psx_poller.sv
// Bench for psx_poller: a pad model per port answers on MISO/ACK, a scoreboard
// queue holds the bytes each poll should produce, and a monitor checks every strobe.
module tb_psx_poller;

  localparam int unsigned HP = 10, NP = 2, PM = 9, AT = 1000;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, auto_en = 1'b0;
  logic          miso = 1'b1, ack = 1'b1;
  logic [NP-1:0] cs, nopad;
  logic          sclk, mosi, vld, fe, busy;
  logic [7:0]    rx_byte;
  logic [4:0]    idx;
  logic [1:0]    port;

  psx_poller #(.HALF_PER(HP), .N_PORTS(NP), .PKT_MAX(PM), .ACK_TIMEOUT(AT)) dut (
    .iCLK       (clk),
    .iRESET     (rst_n),
    .iSTART     (start),
    .iAUTO      (auto_en),
    .oCS        (cs),
    .oCLK       (sclk),
    .oMOSI      (mosi),
    .iMISO      (miso),
    .iACK       (ack),
    .oBYTE      (rx_byte),
    .oBYTE_VLD  (vld),
    .oBYTE_IDX  (idx),
    .oPORT      (port),
    .oFRAME_END (fe),
    .oNO_PAD    (nopad),
    .oBUSY      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] port;
    logic [4:0] idx;
    logic [7:0] data;
    logic       fe;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0, n_pass = 0;
  logic [7:0] pad_mem [NP][PM];
  bit         ack_en [NP];
  logic [1:0] nopad_exp = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s", name);
  endtask

  // Reference rules: length from the ID nibble, fixed command bytes.
  function automatic int exp_len(input logic [7:0] id);
    int l;
    l = 3 + 2 * int'(id[3:0]);
    return (l > int'(PM)) ? int'(PM) : l;
  endfunction

  function automatic logic [7:0] exp_cmd(input int i);
    return (i == 0) ? 8'h01 : (i == 1) ? 8'h42 : 8'h00;
  endfunction

  // Queue the strobes one poll of every port should give.
  task automatic push_poll();
    exp_t e;
    int   l;
    for (int p = 0; p < int'(NP); p++) begin
      if (ack_en[p]) begin
        l = exp_len(pad_mem[p][1]);
        for (int i = 0; i < l; i++) begin
          e.port = 2'(p); e.idx = 5'(i); e.data = pad_mem[p][i]; e.fe = (i == l - 1);
          exp_q.push_back(e);
        end
        nopad_exp[p] = 1'b0;
      end else begin
        e.port = 2'(p); e.idx = 5'd0; e.data = pad_mem[p][0]; e.fe = 1'b0;
        exp_q.push_back(e);
        nopad_exp[p] = 1'b1;
      end
    end
  endtask

  task automatic setup_pads(input logic [7:0] id0, input logic [7:0] id1);
    for (int p = 0; p < int'(NP); p++)
      for (int i = 0; i < int'(PM); i++) pad_mem[p][i] = 8'($urandom);
    pad_mem[0][1] = id0;
    pad_mem[1][1] = id1;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while (busy && n < 30000) begin @(negedge clk); n++; end
    check("poll_finished_busy", busy, 0);
  endtask

  // Pad model: drives MISO after falling edges, checks MOSI on rising edges, ACKs after bytes.
  int   pb = 0, pbyte = 0, ack_t = 0, psel = 0;
  logic prev_sclk = 1'b1;
  logic [7:0] mosi_sr = 8'h00;
  always @(negedge clk) begin
    if (ack_t > 0) ack_t--;
    ack = !(ack_t > 0 && ack_t <= 4);
    if (cs == 2'b11) begin
      pb = 0; pbyte = 0; ack_t = 0; ack = 1'b1;
    end else begin
      psel = cs[0] ? 1 : 0;
      if (prev_sclk && !sclk) miso = pad_mem[psel][(pbyte < int'(PM)) ? pbyte : 0][pb];
      if (!prev_sclk && sclk) begin
        mosi_sr[pb] = mosi;
        pb++;
        if (pb == 8) begin
          check("mosi_byte", mosi_sr, exp_cmd(pbyte));
          pb = 0;
          pbyte++;
          if (ack_en[psel] && pbyte < exp_len(pad_mem[psel][1]))
            ack_t = int'(HP) + 6 + int'($urandom_range(0, 20));
        end
      end
    end
    prev_sclk = sclk;
  end

  // Monitor: pops the scoreboard on each strobe, tracks select overlap and idle gaps.
  int         p0_starts = 0, fe_cnt = 0, multi_cs = 0, cs1_low = 0, gaps = 0, vld_cnt = 0;
  bit         gap_mon = 1'b0;
  logic [1:0] fe_ports[$];
  always @(negedge clk) begin
    exp_t e;
    if (!cs[0] && !cs[1]) multi_cs++;
    if (!cs[1]) cs1_low++;
    if (gap_mon && !busy) gaps++;
    if (vld) begin
      vld_cnt++;
      if (port == 2'd0 && idx == 5'd0) p0_starts++;
      if (fe) begin fe_cnt++; fe_ports.push_back(port); end
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_strobe: got port %0d idx %0d byte %0h, required none",
                 port, idx, rx_byte);
        n_checks++;
      end else begin
        e = exp_q.pop_front();
        check("strobe_port", port, e.port);
        check("strobe_idx", idx, e.idx);
        check("strobe_byte", rx_byte, e.data);
        check("strobe_frame_end", fe, e.fe);
      end
    end else if (fe) begin
      fail("frame_end_without_strobe");
    end
  end

  initial begin
    int n, lo, hi;
    ack_en[0] = 1'b1; ack_en[1] = 1'b1;
    setup_pads(8'h41, 8'h73);
    repeat (3) @(negedge clk);
    check("rst_cs", cs, 2'b11);
    check("rst_clk", sclk, 1);
    check("rst_mosi", mosi, 0);
    check("rst_byte", rx_byte, 0);
    check("rst_vld", vld, 0);
    check("rst_idx", idx, 0);
    check("rst_port", port, 0);
    check("rst_fe", fe, 0);
    check("rst_nopad", nopad, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ID 0x41 on port 0 (5 bytes), ID 0x73 on port 1 (9 bytes).
    pad_mem[0][2] = 8'h5A; pad_mem[0][3] = 8'hFF; pad_mem[0][4] = 8'h7F;
    push_poll();
    pulse_start();
    wait_idle();
    check("s1_nopad", nopad, nopad_exp);
    check("s1_drained", exp_q.size(), 0);

    // Port 1 never ACKs: timeout flag, then cleared by a full packet.
    setup_pads(8'h41, 8'h73);
    ack_en[1] = 1'b0;
    push_poll();
    cs1_low = 0;
    pulse_start();
    wait_idle();
    check("s2_nopad_set", nopad, 2'b10);
    check("s2_cs_high", cs, 2'b11);
    lo = int'(AT + 16 * HP); hi = int'(AT + 18 * HP);
    n_checks++;
    if (cs1_low >= lo && cs1_low <= hi) n_pass++;
    else $display("FAIL s2_timeout_len: got %0d cycles required %0d..%0d", cs1_low, lo, hi);
    ack_en[1] = 1'b1;
    push_poll();
    pulse_start();
    wait_idle();
    check("s2_nopad_clear", nopad, 2'b00);
    check("s2_drained", exp_q.size(), 0);

    // Auto mode for three back-to-back polls.
    setup_pads(8'h40, 8'h42);
    push_poll(); push_poll(); push_poll();
    fe_cnt = 0; fe_ports.delete(); p0_starts = 0; gaps = 0;
    @(negedge clk); auto_en = 1'b1;
    @(negedge clk); @(negedge clk);
    gap_mon = 1'b1;
    n = 0;
    while (p0_starts < 3 && n < 30000) begin @(negedge clk); n++; end
    check("s3_third_poll_seen", p0_starts, 3);
    auto_en = 1'b0;
    gap_mon = 1'b0;
    wait_idle();
    check("s3_frame_ends", fe_cnt, 6);
    for (int i = 0; i < fe_ports.size() && i < 6; i++) check("s3_port_seq", fe_ports[i], i % 2);
    check("s3_no_gaps", gaps, 0);
    check("s3_drained", exp_q.size(), 0);

    // Start while busy is ignored.
    setup_pads(8'h41, 8'h41);
    push_poll();
    pulse_start();
    repeat (300) @(negedge clk);
    check("s4_busy_mid", busy, 1);
    pulse_start();
    wait_idle();
    repeat (300) @(negedge clk);
    check("s4_stays_idle", busy, 0);
    check("s4_drained", exp_q.size(), 0);

    // Reset in the middle of byte 2.
    setup_pads(8'h73, 8'h41);
    push_poll();
    pulse_start();
    n = 0;
    while (!(pbyte == 2 && pb == 3 && cs[0] == 1'b0) && n < 5000) begin @(negedge clk); n++; end
    check("s5_reached_byte2", pbyte, 2);
    n = vld_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("s5_cs", cs, 2'b11);
    check("s5_clk", sclk, 1);
    check("s5_mosi", mosi, 0);
    check("s5_busy", busy, 0);
    check("s5_vld", vld, 0);
    nopad_exp = 2'b00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("s5_no_strobe", vld_cnt, n);
    exp_q.delete();
    push_poll();
    pulse_start();
    wait_idle();
    check("s5_repoll_drained", exp_q.size(), 0);

    // Random IDs, data and ACK behaviour.
    for (int r = 0; r < 3; r++) begin
      setup_pads(8'($urandom), 8'($urandom));
      ack_en[0] = ($urandom_range(0, 3) != 0);
      ack_en[1] = ($urandom_range(0, 3) != 0);
      push_poll();
      pulse_start();
      wait_idle();
      check("rnd_nopad", nopad, nopad_exp);
      check("rnd_drained", exp_q.size(), 0);
    end

    check("single_cs_low", multi_cs, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
